// File: rtl/csr_perf_counters_pkg.sv
// Shared types and CSR addresses for the performance-counter CSR unit.
package csr_perf_counters_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_t;

    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;

    function automatic logic [11:0] cnt_offset(int j);
        return (j == 0) ? 12'd0 : 12'(j + 1);
    endfunction

    function automatic logic [31:0] csr_alu(csr_op_t op, logic [31:0] old_v, logic [31:0] wdata);
        case (op)
            CSR_WRITE: return wdata;
            CSR_SET:   return old_v | wdata;
            CSR_CLEAR: return old_v & ~wdata;
            default:   return old_v;
        endcase
    endfunction

endpackage

// File: rtl/csr_perf_counters_if.sv
// CSR request/response port: request valid for one cycle, response exactly one cycle later.
interface csr_perf_counters_if;
    logic        csr_req;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_req, csr_addr, csr_op, csr_wdata,
        input  csr_ack, csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_req, csr_addr, csr_op, csr_wdata,
        output csr_ack, csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_perf_counters_counter.sv
// One CNT_W-bit counter with 32-bit half writes, inhibit and registered wrap pulse.
module csr_perf_counters_counter #(
    parameter int CNT_W = 64,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc_i,
    input  logic             inhibit_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] q_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W:0]   sum;

    // A write to either half suppresses the whole counter's increment that cycle.
    always_comb begin
        sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc_i);
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]       = wdata_i;
            if (wr_hi_i) cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
        end else if (!inhibit_i) begin
            cnt_d = sum[CNT_W-1:0];
            ovf_d = sum[CNT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_o   = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/csr_perf_counters.sv
// Performance-counter CSR unit: cycle, instret and NUM_HPM event counters behind a registered CSR port.
module csr_perf_counters
    import csr_perf_counters_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int RETIRE_W   = 2,
    parameter int CNT_W      = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    csr_perf_counters_if.slave            csr,
    input  logic [$clog2(RETIRE_W+1)-1:0] retire_cnt,
    input  logic [NUM_EVENTS-1:0]         event_i,
    output logic [NUM_HPM+1:0]            overflow_o
);

    localparam int NCNT = NUM_HPM + 2;
    localparam int RW_W = $clog2(RETIRE_W + 1);
    localparam int EV_W = $clog2(NUM_EVENTS + 1);

    logic [NCNT-1:0][CNT_W-1:0]   cnt_q;
    logic [NCNT-1:0][RW_W-1:0]    inc;
    logic [NCNT-1:0]              inh_q, inh_d, wr_lo, wr_hi, cnt_oh;
    logic [NUM_HPM-1:0][EV_W-1:0] ev_q, ev_d;
    logic [NUM_HPM-1:0]           ev_hit, ev_oh;
    logic [RW_W-1:0]              ret_clamped;

    csr_op_t     op;
    logic        cnt_sel, cnt_ro, cnt_hi, ev_sel, inh_sel, illegal, do_wr;
    logic [CNT_W-1:0] cnt_val;
    logic [31:0] ev_val, inh_csr, old_val, new_val;

    logic        ack_q, ack_d, ill_q, ill_d;
    logic [31:0] rdata_q, rdata_d;

    // Event select and per-counter increment amounts
    always_comb begin
        ret_clamped = (retire_cnt > RW_W'(RETIRE_W)) ? RW_W'(RETIRE_W) : retire_cnt;
        for (int i = 0; i < NUM_HPM; i++) begin
            ev_hit[i] = 1'b0;
            for (int k = 1; k <= NUM_EVENTS; k++)
                if (ev_q[i] == EV_W'(k)) ev_hit[i] = event_i[k-1];
        end
        inc[0] = RW_W'(1);
        inc[1] = ret_clamped;
        for (int i = 0; i < NUM_HPM; i++) inc[2+i] = RW_W'(ev_hit[i]);
    end

    // Address decode and pre-update read value
    always_comb begin
        op      = csr_op_t'(csr.csr_op);
        cnt_sel = 1'b0;
        cnt_ro  = 1'b0;
        cnt_hi  = 1'b0;
        cnt_oh  = '0;
        cnt_val = '0;
        ev_sel  = 1'b0;
        ev_oh   = '0;
        ev_val  = '0;
        for (int j = 0; j < NCNT; j++) begin
            if (csr.csr_addr == CSR_CYCLE + cnt_offset(j)) begin
                cnt_sel = 1'b1; cnt_ro = 1'b1; cnt_oh[j] = 1'b1; cnt_val = cnt_q[j];
            end
            if (csr.csr_addr == CSR_CYCLEH + cnt_offset(j)) begin
                cnt_sel = 1'b1; cnt_ro = 1'b1; cnt_hi = 1'b1; cnt_oh[j] = 1'b1; cnt_val = cnt_q[j];
            end
            if (csr.csr_addr == CSR_MCYCLE + cnt_offset(j)) begin
                cnt_sel = 1'b1; cnt_oh[j] = 1'b1; cnt_val = cnt_q[j];
            end
            if (csr.csr_addr == CSR_MCYCLEH + cnt_offset(j)) begin
                cnt_sel = 1'b1; cnt_hi = 1'b1; cnt_oh[j] = 1'b1; cnt_val = cnt_q[j];
            end
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr.csr_addr == CSR_MHPMEVENT3 + 12'(i)) begin
                ev_sel = 1'b1; ev_oh[i] = 1'b1; ev_val = 32'(ev_q[i]);
            end
        end
        inh_sel = (csr.csr_addr == CSR_MCOUNTINHIBIT);

        inh_csr    = '0;
        inh_csr[0] = inh_q[0];
        inh_csr[2] = inh_q[1];
        for (int i = 0; i < NUM_HPM; i++) inh_csr[3+i] = inh_q[2+i];

        if (cnt_sel)      old_val = cnt_hi ? 32'(cnt_val[CNT_W-1:32]) : cnt_val[31:0];
        else if (ev_sel)  old_val = ev_val;
        else if (inh_sel) old_val = inh_csr;
        else              old_val = '0;

        illegal = !(cnt_sel || ev_sel || inh_sel) || (cnt_ro && op != CSR_READ);
        new_val = csr_alu(op, old_val, csr.csr_wdata);
        do_wr   = csr.csr_req && !illegal && (op != CSR_READ);
    end

    // State updates from the request
    always_comb begin
        wr_lo = (do_wr && cnt_sel && !cnt_hi) ? cnt_oh : '0;
        wr_hi = (do_wr && cnt_sel &&  cnt_hi) ? cnt_oh : '0;

        inh_d = inh_q;
        if (do_wr && inh_sel) begin
            inh_d[0] = new_val[0];
            inh_d[1] = new_val[2];
            for (int i = 0; i < NUM_HPM; i++) inh_d[2+i] = new_val[3+i];
        end

        ev_d = ev_q;
        for (int i = 0; i < NUM_HPM; i++)
            if (do_wr && ev_oh[i])
                ev_d[i] = (new_val > 32'(NUM_EVENTS)) ? '0 : EV_W'(new_val);

        ack_d   = csr.csr_req;
        ill_d   = csr.csr_req && illegal;
        rdata_d = (csr.csr_req && !illegal) ? old_val : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_q   <= '0;
            ev_q    <= '0;
            ack_q   <= 1'b0;
            ill_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            inh_q   <= inh_d;
            ev_q    <= ev_d;
            ack_q   <= ack_d;
            ill_q   <= ill_d;
            rdata_q <= rdata_d;
        end
    end

    assign csr.csr_ack     = ack_q;
    assign csr.csr_illegal = ill_q;
    assign csr.csr_rdata   = rdata_q;

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        csr_perf_counters_counter #(
            .CNT_W (CNT_W),
            .INC_W (RW_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc_i     (inc[g]),
            .inhibit_i (inh_q[g]),
            .wr_lo_i   (wr_lo[g]),
            .wr_hi_i   (wr_hi[g]),
            .wdata_i   (new_val),
            .q_o       (cnt_q[g]),
            .ovf_o     (overflow_o[g])
        );
    end

endmodule

// File: tb/tb_csr_perf_counters.sv
// Scoreboard bench: requests push expected responses, a negedge monitor pops and compares on each ack.
module tb_csr_perf_counters;
    import csr_perf_counters_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] retire_cnt;
    logic [7:0] event_i;
    logic [5:0] overflow_o;

    csr_perf_counters_if bus();

    csr_perf_counters #(
        .NUM_HPM(4), .NUM_EVENTS(8), .RETIRE_W(2), .CNT_W(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .csr        (bus),
        .retire_cnt (retire_cnt),
        .event_i    (event_i),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] rdata;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passes = 0;
    logic [63:0] cyc_exp = '0;   // model of mcycle: edges since reset, minus inhibited ones
    logic        inh_cy  = 1'b0;
    logic [63:0] old;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (bus.csr_ack === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ack: got ack with rdata 0x%0h, expected no ack", bus.csr_rdata);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("rdata@%03h", mon_e.addr), 64'(bus.csr_rdata), 64'(mon_e.rdata));
                check($sformatf("illegal@%03h", mon_e.addr), 64'(bus.csr_illegal), 64'(mon_e.ill));
            end
        end
    end

    task automatic tick();
        logic was_rst;
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) cyc_exp = '0;
        else if (!inh_cy) cyc_exp = cyc_exp + 64'd1;
    endtask

    task automatic csr(input logic [11:0] a, input csr_op_t op, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eill);
        bus.csr_req   = 1'b1;
        bus.csr_addr  = a;
        bus.csr_op    = op;
        bus.csr_wdata = wd;
        sb.push_back('{a, erd, eill});
        tick();
        bus.csr_req   = 1'b0;
        bus.csr_op    = CSR_READ;
        bus.csr_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        retire_cnt = '0;
        event_i = '0;
        // A request during reset must be dropped
        bus.csr_req = 1'b1; bus.csr_addr = CSR_CYCLE; bus.csr_op = CSR_READ; bus.csr_wdata = '0;
        repeat (3) tick();
        bus.csr_req = 1'b0;
        rst = 1'b0;
        check("rst_ack", 64'(bus.csr_ack), 64'd0);
        check("rst_rdata", 64'(bus.csr_rdata), 64'd0);
        check("rst_illegal", 64'(bus.csr_illegal), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);

        // cycle after 10 idle cycles, zero offset
        repeat (10) tick();
        csr(12'hC00, CSR_READ, 0, 32'd10, 1'b0);
        csr(12'hC80, CSR_READ, 0, 32'd0, 1'b0);

        // instret: 5 x 2, then wrap from all-ones
        retire_cnt = 2'd2;
        repeat (5) tick();
        retire_cnt = 2'd0;
        csr(12'hC02, CSR_READ, 0, 32'd10, 1'b0);
        csr(12'hB02, CSR_WRITE, 32'hFFFF_FFFF, 32'd10, 1'b0);
        csr(12'hB82, CSR_WRITE, 32'hFFFF_FFFF, 32'd0, 1'b0);
        retire_cnt = 2'd1;
        tick();
        retire_cnt = 2'd0;
        check("ovf_instret_pulse", 64'(overflow_o), 64'h2);
        tick();
        check("ovf_instret_once", 64'(overflow_o), 64'h0);
        csr(12'hC02, CSR_READ, 0, 32'd0, 1'b0);
        csr(12'hC82, CSR_READ, 0, 32'd0, 1'b0);
        // retire_cnt=3 clamps to 2 per cycle
        retire_cnt = 2'd3;
        repeat (2) tick();
        retire_cnt = 2'd0;
        csr(12'hC02, CSR_READ, 0, 32'd4, 1'b0);

        // hpm3 counts event_i[1] only
        csr(12'h323, CSR_WRITE, 32'd2, 32'd0, 1'b0);
        repeat (3) begin
            event_i = 8'h02; tick();
            event_i = 8'h00; tick();
        end
        event_i = 8'h01;
        repeat (4) tick();
        event_i = 8'h00;
        csr(12'hC03, CSR_READ, 0, 32'd3, 1'b0);
        csr(12'hB03, CSR_WRITE, 32'd5, 32'd3, 1'b0);
        csr(12'hB83, CSR_WRITE, 32'd1, 32'd0, 1'b0);
        csr(12'hC03, CSR_READ, 0, 32'd5, 1'b0);
        csr(12'hC83, CSR_READ, 0, 32'd1, 1'b0);
        // mhpmevent WARL
        csr(12'h324, CSR_WRITE, 32'd9, 32'd0, 1'b0);
        csr(12'h324, CSR_READ, 0, 32'd0, 1'b0);
        csr(12'h324, CSR_WRITE, 32'd8, 32'd0, 1'b0);
        csr(12'h324, CSR_READ, 0, 32'd8, 1'b0);

        // mcountinhibit: write cycle still counts, then frozen
        csr(12'h320, CSR_WRITE, 32'hFFFF_FFFF, 32'd0, 1'b0);
        inh_cy = 1'b1;
        csr(12'h320, CSR_READ, 0, 32'h7D, 1'b0);
        csr(12'hC00, CSR_READ, 0, cyc_exp[31:0], 1'b0);
        repeat (5) tick();
        csr(12'hC00, CSR_READ, 0, cyc_exp[31:0], 1'b0);
        csr(12'h320, CSR_CLEAR, 32'hFFFF_FFFF, 32'h7D, 1'b0);
        inh_cy = 1'b0;
        csr(12'hC00, CSR_READ, 0, cyc_exp[31:0], 1'b0);
        csr(12'hC00, CSR_READ, 0, cyc_exp[31:0], 1'b0);

        // csrrs returns old value; the set replaces that cycle's increment
        old = cyc_exp;
        csr(12'hB00, CSR_SET, 32'h100, old[31:0], 1'b0);
        cyc_exp = old | 64'h100;
        csr(12'hC00, CSR_READ, 0, cyc_exp[31:0], 1'b0);
        csr(12'hC00, CSR_WRITE, 32'hDEAD, 32'd0, 1'b1);
        csr(12'hC80, CSR_SET, 32'h1, 32'd0, 1'b1);
        csr(12'hC00, CSR_READ, 0, cyc_exp[31:0], 1'b0);
        csr(12'h7C0, CSR_READ, 0, 32'd0, 1'b1);
        csr(12'hC01, CSR_READ, 0, 32'd0, 1'b1);

        // back-to-back requests, then reset mid-stream
        for (int i = 0; i < 8; i++)
            csr((i % 2 == 1) ? 12'hB00 : 12'hC00, CSR_READ, 0, cyc_exp[31:0], 1'b0);
        bus.csr_req = 1'b1; bus.csr_addr = 12'hC00; bus.csr_op = CSR_READ;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.csr_req = 1'b0;
        check("post_rst_ack", 64'(bus.csr_ack), 64'd0);
        check("post_rst_overflow", 64'(overflow_o), 64'd0);
        csr(12'hC00, CSR_READ, 0, 32'd0, 1'b0);
        csr(12'hB02, CSR_READ, 0, 32'd0, 1'b0);
        csr(12'h323, CSR_READ, 0, 32'd0, 1'b0);
        csr(12'h320, CSR_READ, 0, 32'd0, 1'b0);
        csr(12'hC03, CSR_READ, 0, 32'd0, 1'b0);
        csr(12'hC83, CSR_READ, 0, 32'd0, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
